dht11_cmd_ctrl: RTL

//  Command/response controller wrapped around the dht11 reader. Accepts a 1-byte

---
 rtl/dht11_cmd_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dht11_cmd_ctrl.sv
// Command/response controller around the DHT11 reader: takes one command byte,
// runs one acquisition, verifies the checksum and returns a 2-byte {code, data} response.
module dht11_cmd_ctrl #(
  parameter int unsigned P_ARM_CYC   = 16,
  parameter int unsigned P_MEAS_CYC  = 5_000_000,
  parameter int unsigned P_DRAIN_CYC = 20_000_000
) (
  input  logic       i_Clock,
  input  logic       i_Rst,
  input  logic       i_Cmd_Valid,
  input  logic [7:0] i_Cmd,
  output logic       o_Cmd_Ready,
  output logic       o_Dht_En,
  output logic       o_Dht_Rst,
  input  logic       i_Dht_Wait,
  input  logic       i_Dht_Error,
  input  logic [7:0] i_Hum_Int,
  input  logic [7:0] i_Hum_Float,
  input  logic [7:0] i_Temp_Int,
  input  logic [7:0] i_Temp_Float,
  input  logic [7:0] i_Crc,
  output logic [7:0] o_Tx_Data,
  output logic       o_Tx_Valid,
  input  logic       i_Tx_Ready,
  output logic       o_Busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TRIG  = 3'd1,
    S_ARM   = 3'd2,
    S_MEAS  = 3'd3,
    S_CHECK = 3'd4,
    S_DRAIN = 3'd5,
    S_SEND0 = 3'd6,
    S_SEND1 = 3'd7
  } state_t;

  localparam logic [24:0] C_ARM_LAST   = 25'(P_ARM_CYC - 1);
  localparam logic [24:0] C_MEAS_LAST  = 25'(P_MEAS_CYC - 1);
  localparam logic [24:0] C_DRAIN_LAST = 25'(P_DRAIN_CYC - 1);
  localparam logic [24:0] C_CNT_MAX    = 25'h1FF_FFFF;

  state_t      state_q, state_d;
  logic [24:0] cnt_q, cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  code_q, code_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  hi_q, hi_d, hf_q, hf_d, ti_q, ti_d, tf_q, tf_d, crc_q, crc_d;
  logic        en_q;
  logic [7:0]  sum_s;

  assign sum_s = hi_q + hf_q + ti_q + tf_q;

  // State and datapath registers
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 25'd0;
      cmd_q   <= 8'd0;
      code_q  <= 8'd0;
      data_q  <= 8'd0;
      hi_q    <= 8'd0;
      hf_q    <= 8'd0;
      ti_q    <= 8'd0;
      tf_q    <= 8'd0;
      crc_q   <= 8'd0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      code_q  <= code_d;
      data_q  <= data_d;
      hi_q    <= hi_d;
      hf_q    <= hf_d;
      ti_q    <= ti_d;
      tf_q    <= tf_d;
      crc_q   <= crc_d;
      en_q    <= 1'b1;
    end
  end

  // Next-state and response selection
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    code_d  = code_q;
    data_d  = data_q;
    hi_d    = hi_q;
    hf_d    = hf_q;
    ti_d    = ti_q;
    tf_d    = tf_q;
    crc_d   = crc_q;
    case (state_q)
      S_IDLE: begin
        if (i_Cmd_Valid) begin
          cmd_d = i_Cmd;
          if (i_Cmd <= 8'h02) begin
            state_d = S_TRIG;
          end else begin
            code_d  = 8'hE0;
            data_d  = i_Cmd;
            state_d = S_SEND0;
          end
        end
      end
      S_TRIG: state_d = S_ARM;
      S_ARM: begin
        if (i_Dht_Wait) begin
          state_d = S_MEAS;
        end else if (cnt_q >= C_ARM_LAST) begin
          code_d  = 8'h1F;
          data_d  = 8'h00;
          state_d = S_DRAIN;
        end
      end
      S_MEAS: begin
        // Error wins over Wait falling in the same cycle
        if (i_Dht_Error || (i_Dht_Wait && cnt_q >= C_MEAS_LAST)) begin
          code_d  = 8'h1F;
          data_d  = 8'h00;
          state_d = S_DRAIN;
        end else if (!i_Dht_Wait) begin
          hi_d    = i_Hum_Int;
          hf_d    = i_Hum_Float;
          ti_d    = i_Temp_Int;
          tf_d    = i_Temp_Float;
          crc_d   = i_Crc;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = S_SEND0;
        if (sum_s != crc_q) begin
          code_d = 8'h2F;
          data_d = sum_s;
        end else begin
          case (cmd_q)
            8'h00:   begin code_d = 8'h08; data_d = 8'h00; end
            8'h01:   begin code_d = 8'h09; data_d = ti_q;  end
            8'h02:   begin code_d = 8'h0A; data_d = hi_q;  end
            default: begin code_d = 8'h1F; data_d = 8'h00; end
          endcase
        end
      end
      S_DRAIN: begin
        if (!i_Dht_Wait || cnt_q >= C_DRAIN_LAST) state_d = S_SEND0;
      end
      S_SEND0: begin
        if (i_Tx_Ready) state_d = S_SEND1;
      end
      S_SEND1: begin
        if (i_Tx_Ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = 25'd0;
    end else if (cnt_q == C_CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 25'd1;
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    o_Cmd_Ready = (state_q == S_IDLE);
    o_Busy      = (state_q != S_IDLE);
    o_Dht_Rst   = (state_q == S_TRIG);
    o_Dht_En    = en_q;
    o_Tx_Valid  = (state_q == S_SEND0) || (state_q == S_SEND1);
    case (state_q)
      S_SEND0: o_Tx_Data = code_q;
      S_SEND1: o_Tx_Data = data_q;
      default: o_Tx_Data = 8'h00;
    endcase
  end

endmodule
